hs2way_arbiter: RTL
===================

Name: hs2way_arbiter

Overview:
- Shares one hs2way master channel between g_num_req hs2way requesters.
- Uses round-robin grant with bounded bursts.
- Has a single registered output stage, so each beat costs one cycle of latency.
- Sits between several producer agents/blocks and a single downstream hs2way consumer.

Parameters:
- g_data_size, 8, payload width in bits.
- g_num_req, 4, number of requesters (2..16).
- g_max_burst, 4, max consecutive beats granted to one requester before rearbitration (1..255).

Ports:
- p_clock  input  1  single clock; all logic on rising edge.
- p_reset_n  input  1  reset, asynchronous, active-low.
- p_in_push  input  g_num_req  per-requester push (beat valid).
- p_in_wait_n  output  g_num_req  per-requester wait_n (1 = beat accepted this edge if pushing).
- p_in_data  input  g_num_req*g_data_size  packed payloads; requester i at bits [i*g_data_size +: g_data_size].
- p_out_push  output  1  downstream push.
- p_out_wait_n  input  1  downstream wait_n.
- p_out_data  output  g_data_size  downstream payload.
- p_grant_id  output  $clog2(g_num_req)  index of current/last granted requester.
- p_busy  output  1  high while in BURST state.

Behaviour:
- Transfer rule on both sides: a beat moves on a rising edge when push=1 and wait_n=1.
- Push must hold stable with data until accepted; the arbiter obeys this on p_out_*.
- Reset (async assert, sync release): p_out_push=0, p_out_data=0, p_in_wait_n=0, p_grant_id=0, p_busy=0, state=IDLE, burst counter=0, round-robin pointer=0.
- Output register: one entry, flag full = p_out_push.
  - can_load = !full || p_out_wait_n.
- FSM states:
  - IDLE: no grant. If any p_in_push is set, pick requester r (round-robin starting at pointer), go to BURST, set p_grant_id=r, burst_cnt=0. No beat is accepted in the picking cycle.
  - BURST: p_in_wait_n[r] = can_load; all other wait_n bits = 0.
    - On a beat from r: load the output register, burst_cnt++.
    - Leave BURST for IDLE when r accepts its g_max_burst-th beat or p_in_push[r]=0. Pointer = r+1 (mod g_num_req, wraps to 0).
- Arbitration cost: one dead cycle per grant change. Sustained single-requester throughput is g_max_burst/(g_max_burst+1).
- Output register update:
  - Loaded beat sets p_out_push=1 with data.
  - Downstream accept with no new load clears p_out_push.
  - Simultaneous downstream accept and new load: data replaced, push stays 1 (no bubble).
- Downstream stall (p_out_wait_n=0 while full): can_load=0, the granted requester sees wait_n=0, and the burst counter holds. The stall does not end the burst.
- Round-robin: search order pointer, pointer+1, ... wrapping. A single active requester is re-granted after each IDLE cycle.
- p_grant_id holds its value in IDLE until the next grant.
- p_busy=1 exactly in BURST.
- Async reset mid-burst: the beat in the output register is dropped and all state returns to reset values immediately.

Optional Feature:
- HS2WAY_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins every arbitration; the pointer is unused and held at 0. g_max_burst still bounds bursts.
- Undefined: round-robin as above.

Decomposition:
- Package hs2way_arb_pkg:
  - state enum t_arb_state {ARB_IDLE, ARB_BURST}.
  - constant/function for grant-id width (clog2 with min 1).
- Sub-module hs2way_rr_picker (combinational):
  - inputs: request vector, pointer.
  - outputs: found flag, index.
  - fixed-priority variant selected by the macro inside it.

Test Plan:
- Reset: hold p_reset_n=0 with random push -> all outputs 0. Deassert with p_in_push=4'b0001 and p_out_wait_n=1 -> grant_id=0 next edge, first beat on p_out_push 2 edges after reset release.
- Burst limit: requester 2 pushes 10 beats continuously (data 0x20..0x29), g_max_burst=4, downstream always ready -> output order 0x20..0x29 with one idle cycle after every 4th beat, grant_id stays 2.
- Round-robin fairness: all 4 requesters push continuously, g_max_burst=1 -> grant_id sequence 0,1,2,3,0,...; each requester gets 25% of beats ±1 over 400 cycles.
- Backpressure: p_out_wait_n=0 for 5 cycles mid-burst -> p_out_push/p_out_data stable, granted p_in_wait_n=0, no beat lost or duplicated (scoreboard compare).
- Early release: requester 1 drops push after 2 of 4 beats while requester 3 waits -> IDLE for 1 cycle, then grant_id=3.
- Reset mid-burst: assert p_reset_n=0 while p_out_push=1 -> p_out_push falls asynchronously. After release, arbitration restarts from pointer 0.

Source files
------------

// File: rtl/hs2way_arb_pkg.sv
// Shared types and helpers for the hs2way round-robin arbiter.
// Optional build macro: HS2WAY_ARB_FIXED_PRIO_EN (fixed lowest-index priority).
package hs2way_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } t_arb_state;

  localparam int BURST_CNT_W = 8;

  function automatic int id_width(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/hs2way_rr_picker.sv
// Combinational requester picker: first set request at or after ptr, wrapping.
// With HS2WAY_ARB_FIXED_PRIO_EN defined the lowest set index wins and ptr is ignored.
module hs2way_rr_picker
  import hs2way_arb_pkg::*;
#(
  parameter int g_num_req = 4,
  parameter int g_id_w    = id_width(g_num_req)
) (
  input  logic [g_num_req-1:0] req,
  input  logic [g_id_w-1:0]    ptr,
  output logic                 found,
  output logic [g_id_w-1:0]    idx
);

  logic [g_id_w-1:0] cand_s;

  // Scan from the farthest offset down so the nearest candidate is the last write.
  always_comb begin
    found  = 1'b0;
    idx    = '0;
    cand_s = '0;
    for (int k = g_num_req - 1; k >= 0; k--) begin
`ifdef HS2WAY_ARB_FIXED_PRIO_EN
      cand_s = g_id_w'(k);
`else
      cand_s = g_id_w'((int'(ptr) + k) % g_num_req);
`endif
      if (req[cand_s]) begin
        found = 1'b1;
        idx   = cand_s;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/hs2way_arbiter.sv
// Shares one hs2way master channel among g_num_req requesters with bounded bursts.
// Optional build macro: HS2WAY_ARB_FIXED_PRIO_EN (fixed priority, pointer held at 0).
module hs2way_arbiter
  import hs2way_arb_pkg::*;
#(
  parameter int g_data_size = 8,
  parameter int g_num_req   = 4,
  parameter int g_max_burst = 4
) (
  input  logic                             p_clock,
  input  logic                             p_reset_n,
  input  logic [g_num_req-1:0]             p_in_push,
  output logic [g_num_req-1:0]             p_in_wait_n,
  input  logic [g_num_req*g_data_size-1:0] p_in_data,
  output logic                             p_out_push,
  input  logic                             p_out_wait_n,
  output logic [g_data_size-1:0]           p_out_data,
  output logic [$clog2(g_num_req)-1:0]     p_grant_id,
  output logic                             p_busy
);

  localparam int ID_W = id_width(g_num_req);
  localparam logic [BURST_CNT_W-1:0] MAX_LAST = BURST_CNT_W'(g_max_burst - 1);

  t_arb_state             state_r;
  logic [ID_W-1:0]        grant_r;
  logic [ID_W-1:0]        ptr_r;
  logic [BURST_CNT_W-1:0] burst_cnt_r;
  logic                   out_push_r;
  logic [g_data_size-1:0] out_data_r;

  logic                   can_load_s;
  logic                   beat_s;
  logic                   pick_found_s;
  logic [ID_W-1:0]        pick_idx_s;
  logic [ID_W-1:0]        next_ptr_s;
  logic [g_num_req-1:0]   wait_n_s;
  logic [g_data_size-1:0] in_data_a [g_num_req];

  for (genvar gi = 0; gi < g_num_req; gi++) begin : g_unpack
    assign in_data_a[gi] = p_in_data[gi*g_data_size +: g_data_size];
  end

  hs2way_rr_picker #(
    .g_num_req (g_num_req),
    .g_id_w    (ID_W)
  ) u_picker (
    .req   (p_in_push),
    .ptr   (ptr_r),
    .found (pick_found_s),
    .idx   (pick_idx_s)
  );

  assign can_load_s = !out_push_r || p_out_wait_n;
  assign beat_s     = (state_r == ARB_BURST) && p_in_push[grant_r] && can_load_s;

  // Pointer moves just past the requester whose burst is ending.
  always_comb begin
`ifdef HS2WAY_ARB_FIXED_PRIO_EN
    next_ptr_s = '0;
`else
    if (grant_r == ID_W'(g_num_req - 1)) begin
      next_ptr_s = '0;
    end else begin
      next_ptr_s = grant_r + ID_W'(1);
    end
`endif
  end

  // Only the granted requester may see wait_n high, and only when the output can load.
  always_comb begin
    wait_n_s = '0;
    if (state_r == ARB_BURST) begin
      wait_n_s[grant_r] = can_load_s;
    end else begin
      wait_n_s = '0;
    end
  end

  // Grant FSM: IDLE picks a requester, BURST forwards beats until limit or push drop.
  always_ff @(posedge p_clock or negedge p_reset_n) begin
    if (!p_reset_n) begin
      state_r     <= ARB_IDLE;
      grant_r     <= '0;
      ptr_r       <= '0;
      burst_cnt_r <= '0;
    end else begin
      case (state_r)
        ARB_IDLE: begin
          if (pick_found_s) begin
            state_r     <= ARB_BURST;
            grant_r     <= pick_idx_s;
            burst_cnt_r <= '0;
          end
        end
        ARB_BURST: begin
          if (beat_s) begin
            burst_cnt_r <= burst_cnt_r + BURST_CNT_W'(1);
            if (burst_cnt_r == MAX_LAST) begin
              state_r <= ARB_IDLE;
              ptr_r   <= next_ptr_s;
            end
          end else if (!p_in_push[grant_r]) begin
            state_r <= ARB_IDLE;
            ptr_r   <= next_ptr_s;
          end
        end
        default: begin
          state_r <= ARB_IDLE;
        end
      endcase
    end
  end

  // Single-entry output register; a load during downstream accept keeps push high.
  always_ff @(posedge p_clock or negedge p_reset_n) begin
    if (!p_reset_n) begin
      out_push_r <= 1'b0;
      out_data_r <= '0;
    end else if (beat_s) begin
      out_push_r <= 1'b1;
      out_data_r <= in_data_a[grant_r];
    end else if (p_out_wait_n) begin
      out_push_r <= 1'b0;
    end
  end

  assign p_in_wait_n = wait_n_s;
  assign p_out_push  = out_push_r;
  assign p_out_data  = out_data_r;
  assign p_grant_id  = grant_r;
  assign p_busy      = (state_r == ARB_BURST);

endmodule
